write_back_queue: RTL and testbench

- Buffers register write-back requests from the execute stage and drains them, one per cycle, into the downstream write-back register stage.
- Downstream interface is wb_en / wb_addr / wb_data.
- Upstream uses a valid/ready handshake; downstream can stall draining.
- Provides a combinational lookup port so younger instructions can forward pending (not yet written) data.

---
 rtl/write_back_queue.sv | 123 ++++++++++++
 tb/tb_write_back_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/write_back_queue.sv
// write_back_queue
//   Small circular buffer between the execute stage and the write-back
//   register stage. Requests are accepted with a valid/ready handshake and
//   drained one per cycle in acceptance order unless the downstream stalls.
//   A combinational lookup port reports the youngest pending write to a
//   given register so younger instructions can forward its data.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_addr/in_data request payload
//   stall               downstream refuses a write this cycle
//   wb_en/wb_addr/wb_data  write issued to downstream this cycle
//   count               number of occupied entries (0..DEPTH)
//   lookup_addr         forwarding query address
//   lookup_hit/lookup_data  youngest pending match (data 0 on a miss)
module write_back_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     stall,
  output logic                     wb_en,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Payload storage is deliberately not reset; the valid bits and count
  // decide what is meaningful.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_reg;

  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              push;
  logic              pop;
  logic              not_empty;

  assign not_empty = (count_reg != '0);

  // Ready depends on registered occupancy only, so a pop in the same cycle
  // never lets a push into a full queue.
  assign in_ready  = !rst && (count_reg != CNT_W'(DEPTH));
  assign wb_en     = !rst && not_empty && !stall;
  assign wb_addr   = not_empty ? addr_mem[head_reg] : '0;
  assign wb_data   = not_empty ? data_mem[head_reg] : '0;
  assign count     = count_reg;

  assign push = in_valid && in_ready;
  assign pop  = wb_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= in_addr;
      data_mem[tail_reg] <= in_data;
    end
  end

  // Per-entry valid bits. A push and a pop never target the same slot in
  // one cycle: that would need head == tail, i.e. empty (no pop) or full
  // (no push).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (push && (tail_reg == PTR_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end else if (pop && (head_reg == PTR_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Walk from oldest (head) to youngest; a later match overrides an
  // earlier one so the youngest pending write wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_reg + PTR_W'(i);
      if (valid_reg[idx] && (addr_mem[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_write_back_queue.sv
module tb_write_back_queue;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [$clog2(DEPTH):0] count;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;

  write_back_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .count(count), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of pending writes, oldest first.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check all outputs mid-cycle against the
  // model, then advance the model across the rising edge.
  task automatic step(input logic r, input logic v, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic s,
                      input logic [ADDR_W-1:0] la);
    logic e_ready, e_wb, e_hit;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data, e_ldata;
    rst = r; in_valid = v; in_addr = a; in_data = d; stall = s; lookup_addr = la;
    @(negedge clk);
    e_ready = !r && (q.size() != DEPTH);
    e_wb    = !r && (q.size() != 0) && !s;
    e_addr  = (q.size() != 0) ? q[0].a : '0;
    e_data  = (q.size() != 0) ? q[0].d : '0;
    e_hit   = 1'b0;
    e_ldata = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == la) begin
        e_hit = 1'b1;
        e_ldata = q[i].d;
        break;
      end
    end
    check("in_ready",    32'(in_ready),    32'(e_ready));
    check("wb_en",       32'(wb_en),       32'(e_wb));
    check("wb_addr",     32'(wb_addr),     32'(e_addr));
    check("wb_data",     32'(wb_data),     32'(e_data));
    check("count",       32'(count),       32'(q.size()));
    check("lookup_hit",  32'(lookup_hit),  32'(e_hit));
    check("lookup_data", 32'(lookup_data), 32'(e_ldata));
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      ent_t n;
      n.a = a;
      n.d = d;
      if (e_wb) void'(q.pop_front());
      if (v && e_ready) q.push_back(n);
    end
    #1;
  endtask

  task automatic idle(input logic s, input logic [ADDR_W-1:0] la);
    step(1'b0, 1'b0, '0, '0, s, la);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; stall = 1'b0; lookup_addr = '0;
    // Reset settles the DUT before the model is trusted for contents.
    @(posedge clk); #1;
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);

    // Single push, then its write-back the next cycle.
    step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd3);
    idle(1'b0, 4'd3);
    idle(1'b0, 4'd3);

    // Fill under stall, a refused fifth request, then drain.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 4'(i), 8'(i * 8'h11), 1'b1, 4'(i));
    step(1'b0, 1'b1, 4'd9, 8'h99, 1'b1, 4'd9);
    for (int i = 0; i < 5; i++) idle(1'b0, 4'd2);

    // Steady-state push/pop with two entries in flight, wrapping pointers.
    step(1'b0, 1'b1, 4'd7, 8'h70, 1'b1, 4'd7);
    step(1'b0, 1'b1, 4'd8, 8'h80, 1'b1, 4'd8);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'(i), 8'(8'hB0 + i), 1'b0, 4'(i));
    for (int i = 0; i < 3; i++) idle(1'b0, '0);

    // Forwarding picks the youngest of repeated writes.
    step(1'b0, 1'b1, 4'd5, 8'h01, 1'b1, 4'd5);
    step(1'b0, 1'b1, 4'd5, 8'h02, 1'b1, 4'd5);
    idle(1'b1, 4'd5);
    idle(1'b1, 4'd6);
    for (int i = 0; i < 3; i++) idle(1'b0, 4'd5);

    // Full queue: stall drops with in_valid high -> pop only, push next edge.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'(10 + i), 8'(8'hC0 + i), 1'b1, 4'd10);
    step(1'b0, 1'b1, 4'd14, 8'hCE, 1'b0, 4'd14);
    step(1'b0, 1'b1, 4'd14, 8'hCE, 1'b1, 4'd14);
    for (int i = 0; i < 5; i++) idle(1'b0, 4'd14);

    // Reset in the middle of activity discards everything.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd2, 8'(8'hD0 + i), 1'b1, 4'd2);
    step(1'b1, 1'b1, 4'd2, 8'hDD, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) idle(1'b0, 4'd2);

    // Randomized traffic over a narrow address range to exercise lookups.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 6),
           4'($urandom_range(0, 3)),
           8'($urandom),
           ($urandom_range(0, 9) < 3),
           4'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
